// File: rtl/crop_frame_buffer_if.sv
// ============================================================================
//  Module   : crop_frame_buffer_if
//  Purpose  : Byte-stream valid/ready bundle between the crop frame buffer
//             (master) and its consumer (slave).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface crop_frame_buffer_if #(
  parameter int PXL_W = 8
);
  logic [PXL_W-1:0] oTxData;
  logic             oTxValid;
  logic             iTxReady;

  modport master (output oTxData, output oTxValid, input iTxReady);
  modport slave  (input oTxData, input oTxValid, output iTxReady);
endinterface

`default_nettype wire

// File: rtl/crop_frame_buffer.sv
// ============================================================================
//  Module   : crop_frame_buffer
//  Purpose  : Captures one 28x28 frame of sampled pixels into a RAM, then
//             streams it out in arrival order over a valid/ready byte link.
//  Options  : CROP_FRAME_CHECKSUM_EN - append a modulo-256 sum of the frame
//             as one trailing byte (requires PXL_W == 8).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module crop_frame_buffer #(
  parameter int N_PIX = 784,
  parameter int PXL_W = 8,
  parameter int CNT_W = 10
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iStart,
  input  logic [PXL_W-1:0]     iPxl,
  input  logic                 iDVAL,
  crop_frame_buffer_if.master  tx,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oOverflow,
  output logic [CNT_W-1:0]     oPxlCnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);
  localparam logic [CNT_W-1:0] N_PIX_C  = CNT_W'(N_PIX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SEND    = 2'd2
`ifdef CROP_FRAME_CHECKSUM_EN
    , S_FLUSH = 2'd3
`endif
  } state_t;

  state_t state, state_nxt;

  // Frame storage (no reset so it maps onto block RAM)
  logic [PXL_W-1:0] mem [0:N_PIX-1];
  logic [PXL_W-1:0] rd_data;

  // Capture side
  logic [CNT_W-1:0] pxl_cnt;
  logic             overflow;
  logic             wr_en;
  logic [CNT_W-1:0] wr_addr;
  logic             last_wr;

  // Send side: RAM read in flight, skid slot, output slot
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] send_cnt;
  logic             rd_pending;
  logic             skid_valid;
  logic [PXL_W-1:0] skid_data;
  logic             out_valid;
  logic [PXL_W-1:0] out_data;
  logic             done;
  logic             accept;
  logic             last_acc;
  logic [1:0]       occ;
  logic             rd_issue;

`ifdef CROP_FRAME_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // A restart pulse redirects the concurrent write to address 0
  assign wr_en    = (state == S_CAPTURE) && iDVAL;
  assign wr_addr  = iStart ? '0 : pxl_cnt;
  assign last_wr  = wr_en && !iStart && (pxl_cnt == LAST_IDX);

  assign accept   = out_valid && tx.iTxReady;
  assign last_acc = (state == S_SEND) && accept && (send_cnt == LAST_IDX);

  // Occupancy of read-in-flight + skid + output; never exceed two so the
  // skid slot always has room for the byte returning from the RAM
  assign occ      = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pending};
  assign rd_issue = (state == S_SEND) && (rd_ptr != N_PIX_C) &&
                    ((occ - {1'b0, accept}) < 2'd2);

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (iStart)  state_nxt = S_CAPTURE;
      S_CAPTURE: if (last_wr) state_nxt = S_SEND;
      S_SEND: begin
        if (last_acc) begin
`ifdef CROP_FRAME_CHECKSUM_EN
          state_nxt = S_FLUSH;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef CROP_FRAME_CHECKSUM_EN
      S_FLUSH:   if (accept)  state_nxt = S_IDLE;
`endif
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Pixel counter and sticky overflow flag
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pxl_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iStart) begin
            pxl_cnt  <= '0;
            overflow <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (iStart) begin
            pxl_cnt  <= wr_en ? CNT_ONE : '0;
            overflow <= 1'b0;
          end else if (wr_en) begin
            pxl_cnt  <= pxl_cnt + CNT_ONE;
          end
        end
        S_SEND: if (iDVAL) overflow <= 1'b1;
        default: ;
      endcase
    end
  end

  // Synchronous-write / synchronous-read frame RAM
  always_ff @(posedge iCLK) begin
    if (wr_en)    mem[wr_addr] <= iPxl;
    if (rd_issue) rd_data      <= mem[rd_ptr];
  end

  // Read pointer, skid register and output register of the byte stream
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rd_ptr     <= '0;
      send_cnt   <= '0;
      rd_pending <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_SEND: begin
          rd_pending <= rd_issue;
          if (rd_issue) rd_ptr   <= rd_ptr + CNT_ONE;
          if (accept)   send_cnt <= send_cnt + CNT_ONE;
          if (!out_valid || accept) begin
            // Output slot free: refill from skid first to keep order
            if (skid_valid) begin
              out_data  <= skid_data;
              out_valid <= 1'b1;
              if (rd_pending) skid_data  <= rd_data;
              else            skid_valid <= 1'b0;
            end else if (rd_pending) begin
              out_data  <= rd_data;
              out_valid <= 1'b1;
            end else begin
              out_valid <= 1'b0;
            end
          end else if (rd_pending) begin
            // Output stalled: park the returning RAM byte
            skid_data  <= rd_data;
            skid_valid <= 1'b1;
          end
          if (last_acc) begin
`ifdef CROP_FRAME_CHECKSUM_EN
            out_data  <= csum;
            out_valid <= 1'b1;
`else
            out_valid <= 1'b0;
            done      <= 1'b1;
`endif
          end
        end
`ifdef CROP_FRAME_CHECKSUM_EN
        S_FLUSH: begin
          if (accept) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
`endif
        default: begin
          rd_ptr     <= '0;
          send_cnt   <= '0;
          rd_pending <= 1'b0;
          skid_valid <= 1'b0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CROP_FRAME_CHECKSUM_EN
  // Modulo-256 frame sum; a restart seeds it with the concurrent pixel
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      csum <= '0;
    end else begin
      if (state == S_IDLE && iStart) begin
        csum <= '0;
      end else if (state == S_CAPTURE) begin
        if (iStart)     csum <= wr_en ? iPxl : 8'd0;
        else if (wr_en) csum <= csum + iPxl;
      end
    end
  end
`endif

  assign tx.oTxData  = out_data;
  assign tx.oTxValid = out_valid;
  assign oBusy       = (state != S_IDLE);
  assign oDone       = done;
  assign oOverflow   = overflow;
  assign oPxlCnt     = pxl_cnt;

endmodule

`default_nettype wire

// File: tb/tb_crop_frame_buffer.sv
// ============================================================================
//  Module   : tb_crop_frame_buffer
//  Purpose  : Directed self-checking bench for crop_frame_buffer with a
//             byte scoreboard fed at capture time and drained on accepts.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_crop_frame_buffer;

  localparam int N  = 784;
  localparam int PW = 8;
  localparam int CW = 10;
`ifdef CROP_FRAME_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          dval  = 1'b0;
  logic [PW-1:0] pxl   = '0;
  logic          busy, done, ovf;
  logic [CW-1:0] cnt;

  crop_frame_buffer_if #(.PXL_W(PW)) tx ();

  crop_frame_buffer #(.N_PIX(N), .PXL_W(PW), .CNT_W(CW)) dut (
    .iCLK      (clk),
    .iRST      (rst),
    .iStart    (start),
    .iPxl      (pxl),
    .iDVAL     (dval),
    .tx        (tx),
    .oBusy     (busy),
    .oDone     (done),
    .oOverflow (ovf),
    .oPxlCnt   (cnt)
  );

  always #5 clk = ~clk;

  // Consumer ready: 0 = never, 1 = always, 2 = repeating 1,0,0,1
  int   rmode = 1;
  int   phase = 0;
  logic rdy   = 1'b0;
  assign tx.iTxReady = rdy;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: begin
        rdy   = (phase == 0) || (phase == 3);
        phase = (phase + 1) % 4;
      end
    endcase
  end

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  q[$];
  logic [7:0]  csum;
  int          acc_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock step; output stream is checked against the scoreboard here
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(tx.oTxValid), 1);
        chk("stall_data", 32'(tx.oTxData), int'(prev_data));
      end
      if (tx.oTxValid && rdy) begin
        acc_cnt++;
        total++;
        assert (q.size() > 0) else begin
          bad++;
          $error("FAIL stream_extra: got byte %0d, expected no byte", tx.oTxData);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("stream_data", 32'(tx.oTxData), int'(e));
        end
      end
      prev_stall = tx.oTxValid && !rdy;
      prev_data  = tx.oTxData;
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  function automatic logic [7:0] pix(input int kind, input int i);
    case (kind)
      0:       return 8'(i);
      1:       return 8'(i * 7 + 3);
      2:       return 8'hAA;
      3:       return 8'h55;
      default: return 8'(i) ^ 8'h5A;
    endcase
  endfunction

  // Back-to-back strobes; returns at the negedge right after the last write
  task automatic feed(input int kind, input int n, input bit push);
    for (int i = 0; i < n; i++) begin
      tick();
      dval = 1'b1;
      pxl  = pix(kind, i);
      if (push) begin
        q.push_back(pxl);
        csum = csum + pxl;
      end
    end
    tick();
    dval = 1'b0;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_trailer();
`ifdef CROP_FRAME_CHECKSUM_EN
    q.push_back(csum);
`endif
  endtask

  task automatic wait_done(output int vcyc, output int gaps, output bit ok);
    bit seen = 1'b0;
    vcyc = 0; gaps = 0; ok = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (tx.oTxValid) begin
        vcyc++;
        seen = 1'b1;
      end else if (seen) begin
        gaps++;
      end
      tick();
    end
  endtask

  initial begin
    int vc, gp, base, viol;
    bit ok;

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(tx.oTxValid), 0);
    chk("reset_data",  32'(tx.oTxData), 0);
    chk("reset_busy",  32'(busy), 0);
    chk("reset_done",  32'(done), 0);
    chk("reset_ovf",   32'(ovf), 0);
    chk("reset_cnt",   32'(cnt), 0);
    rst = 1'b0;

    // ---- iDVAL ignored while idle
    for (int i = 0; i < 5; i++) begin
      tick();
      dval = 1'b1;
      pxl  = 8'h33;
    end
    tick();
    dval = 1'b0;
    tick();
    chk("idle_cnt",  32'(cnt), 0);
    chk("idle_busy", 32'(busy), 0);

    // ---- back-to-back frame, consumer always ready
    rmode = 1;
    pulse_start();
    chk("cap_cnt0", 32'(cnt), 0);
    chk("cap_busy", 32'(busy), 1);
    csum = 8'd0;
    feed(0, N, 1'b1);
    push_trailer();
    chk("full_cnt", 32'(cnt), N);
    chk("valid_e0", 32'(tx.oTxValid), 0);
    tick();
    chk("valid_e1", 32'(tx.oTxValid), 0);
    tick();
    chk("valid_e2", 32'(tx.oTxValid), 1);
    wait_done(vc, gp, ok);
    chk("a_done_seen", 32'(ok), 1);
    chk("a_valid_cycles", 32'(vc), N + EXTRA);
    chk("a_gaps", 32'(gp), 0);
    tick();
    chk("a_done_pulse", 32'(done), 0);
    chk("a_idle", 32'(busy), 0);
    chk("a_ovf", 32'(ovf), 0);
    chk("a_drained", 32'(q.size()), 0);

    // ---- backpressure 1,0,0,1 plus iDVAL during SEND
    rmode = 2;
    pulse_start();
    csum = 8'd0;
    base = acc_cnt;
    feed(1, N, 1'b1);
    push_trailer();
    for (int k = 0; k < 10 && !tx.oTxValid; k++) tick();
    for (int i = 0; i < 3; i++) begin
      dval = 1'b1;
      pxl  = 8'hEE;
      tick();
    end
    dval = 1'b0;
    tick();
    chk("ovf_set", 32'(ovf), 1);
    wait_done(vc, gp, ok);
    chk("b_done_seen", 32'(ok), 1);
    chk("b_accepts", 32'(acc_cnt - base), N + EXTRA);
    tick();
    chk("ovf_sticky", 32'(ovf), 1);
    chk("b_drained", 32'(q.size()), 0);

    // ---- restart mid-capture, restart pulse carries the first pixel
    rmode = 1;
    pulse_start();
    chk("ovf_clear", 32'(ovf), 0);
    feed(2, 100, 1'b0);
    chk("pre_restart_cnt", 32'(cnt), 100);
    csum  = 8'd0;
    tick();
    start = 1'b1;
    dval  = 1'b1;
    pxl   = 8'h55;
    q.push_back(pxl);
    csum  = csum + pxl;
    tick();
    start = 1'b0;
    dval  = 1'b0;
    chk("restart_cnt1", 32'(cnt), 1);
    feed(3, N - 1, 1'b1);
    push_trailer();
    wait_done(vc, gp, ok);
    chk("c_done_seen", 32'(ok), 1);
    chk("c_valid_cycles", 32'(vc), N + EXTRA);
    chk("c_drained", 32'(q.size()), 0);

    // ---- sparse strobes every 21 cycles
    pulse_start();
    csum = 8'd0;
    viol = 0;
    for (int i = 0; i < N; i++) begin
      dval = 1'b1;
      pxl  = 8'(i * 3);
      q.push_back(pxl);
      csum = csum + pxl;
      tick();
      dval = 1'b0;
      if (i < N - 1) begin
        repeat (20) begin
          if (!busy || tx.oTxValid) viol++;
          tick();
        end
      end
    end
    push_trailer();
    chk("sparse_busy_no_send", 32'(viol), 0);
    chk("sparse_valid_e0", 32'(tx.oTxValid), 0);
    chk("sparse_cnt", 32'(cnt), N);
    wait_done(vc, gp, ok);
    chk("d_done_seen", 32'(ok), 1);
    chk("d_drained", 32'(q.size()), 0);

    // ---- asynchronous reset while stalled in SEND
    rmode = 0;
    pulse_start();
    feed(4, N, 1'b0);
    for (int k = 0; k < 5 && !tx.oTxValid; k++) tick();
    chk("e_stalled_valid", 32'(tx.oTxValid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(tx.oTxValid), 0);
    chk("async_data",  32'(tx.oTxData), 0);
    chk("async_busy",  32'(busy), 0);
    chk("async_done",  32'(done), 0);
    chk("async_ovf",   32'(ovf), 0);
    chk("async_cnt",   32'(cnt), 0);
    q.delete();
    tick();
    rst   = 1'b0;
    rmode = 1;
    pulse_start();
    chk("post_rst_cnt",  32'(cnt), 0);
    chk("post_rst_busy", 32'(busy), 1);
    csum = 8'd0;
    feed(4, N, 1'b1);
    push_trailer();
    wait_done(vc, gp, ok);
    chk("f_done_seen", 32'(ok), 1);
    chk("f_valid_cycles", 32'(vc), N + EXTRA);
    chk("f_drained", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crop_frame_buffer.md
Name: crop_frame_buffer

Overview:
- Downstream of the crop/downsample stage: captures the 28x28 = 784 sampled 8-bit pixels (pxl/valid strobes) of one camera frame into an on-chip buffer.
- Once the frame is complete, streams the bytes out in arrival order (row-major) over a valid/ready byte handshake to the SPART transmitter or the NN input loader.
- Decouples the bursty camera-rate sampling from the slower consumer. Exactly one frame is buffered at a time.

Parameters:
- N_PIX, 784, pixels per captured frame (28*28).
- PXL_W, 8, pixel width in bits.
- CNT_W, 10, counter width; must satisfy 2^CNT_W > N_PIX.

Ports:
- iCLK  in  1  system clock; all logic on its rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iStart  in  1  one-cycle pulse: arm capture of the next frame.
- iPxl  in  PXL_W  sampled pixel from the crop stage.
- iDVAL  in  1  iPxl valid, one-cycle strobe, may assert on consecutive cycles.
- oTxData  out  PXL_W  outgoing byte.
- oTxValid  out  1  oTxData valid.
- iTxReady  in  1  consumer accepts the byte when oTxValid && iTxReady.
- oBusy  out  1  high in CAPTURE or SEND.
- oDone  out  1  one-cycle pulse after the final byte is accepted.
- oOverflow  out  1  sticky: iDVAL seen while in SEND; cleared by iStart or reset.
- oPxlCnt  out  CNT_W  pixels captured in the current frame.

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0: oTxData, oTxValid, oBusy, oDone, oOverflow, oPxlCnt. Write and read pointers are 0. Buffer contents are don't-care.
- Storage: N_PIX x PXL_W synchronous-read RAM (infers BRAM). Write when iDVAL is high in CAPTURE. Read latency is 1 cycle.
- States: IDLE, CAPTURE, SEND, FLUSH (FLUSH exists only with the optional feature).
- IDLE:
  - iDVAL is ignored.
  - iStart -> CAPTURE next cycle. Clears oPxlCnt and oOverflow.
- CAPTURE:
  - Each iDVAL writes iPxl at address oPxlCnt, then oPxlCnt increments.
  - The write of pixel index N_PIX-1 moves to SEND on the next cycle. oPxlCnt then holds N_PIX.
  - iStart during CAPTURE restarts capture: oPxlCnt goes to 0, and any iDVAL in that same cycle is written at address 0 (count becomes 1).
- SEND:
  - Read pointer starts at 0. The first oTxValid asserts exactly 2 cycles after entering SEND (prefetch).
  - oTxData and oTxValid hold stable while oTxValid && !iTxReady.
  - On each accept, the next byte must be presented with no bubble when iTxReady is held high. Sustained throughput is 1 byte/cycle, which requires a 1-entry skid/prefetch register.
  - After byte N_PIX-1 is accepted: oTxValid goes to 0, oDone pulses for 1 cycle, and the state returns to IDLE. With CHECKSUM_EN the state goes to FLUSH instead.
  - iDVAL in SEND sets oOverflow and the pixel is dropped. iStart in SEND is ignored.
- oBusy = (state != IDLE).
- Counter arithmetic is unsigned CNT_W and never wraps. Capture stops at N_PIX.
- Reset asserted mid-CAPTURE or mid-SEND aborts immediately. oTxValid drops asynchronously.

Optional Feature:
- Macro: CROP_FRAME_CHECKSUM_EN.
- Defined:
  - An 8-bit modulo-256 sum of all N_PIX captured pixels accumulates during CAPTURE. It clears on the transition into CAPTURE and on an iStart restart.
  - After the last pixel is accepted, FLUSH presents the sum as one extra byte under the same valid/ready rules.
  - oDone pulses after that byte is accepted; the state then returns to IDLE.
  - PXL_W must be 8.
- Undefined: the FLUSH state, the accumulator and its logic are absent. Exactly N_PIX bytes are sent.

Test Plan:
- Reset: assert iRST mid-SEND -> all outputs 0 the same cycle; state IDLE; a subsequent iStart begins a clean capture with oPxlCnt=0.
- Back-to-back capture: iStart, then 784 consecutive iDVAL with iPxl = index[7:0], iTxReady=1 -> oTxValid rises 2 cycles after the last write. Bytes 0x00,0x01..0xFF,0x00.. (784 total) arrive with no gaps, then an oDone pulse. oOverflow=0.
- Backpressure: same frame with iTxReady toggling 1,0,0,1 -> oTxData stable while stalled; no byte duplicated or lost; exactly 784 accepts.
- Restart: iStart, 100 pixels of 0xAA, iStart, 784 pixels of 0x55 -> all 784 output bytes are 0x55; with CHECKSUM_EN the trailer is (784*0x55) mod 256 = 0x50.
- Overflow/ignored inputs: iDVAL pulses while in IDLE -> no write, oPxlCnt=0. iDVAL during SEND -> oOverflow=1 and output stream unchanged. Next iStart clears oOverflow.
- Sparse input: 784 iDVAL strobes spaced 21 cycles apart -> oBusy high throughout; SEND begins only after the 784th strobe.
